// File: rtl/daq_pkg.sv
// Shared constants, frame geometry and FSM state type for the DAQ byte-stream depacketizer.
package daq_pkg;

  localparam int NUM_CHIPS     = 8;
  localparam int NUM_CHAN      = 8;
  localparam int CHIP_W        = $clog2(NUM_CHIPS);
  localparam int CHAN_W        = $clog2(NUM_CHAN);
  localparam int FRAME_SAMPLES = NUM_CHIPS * NUM_CHAN;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC1,
    ST_SEQ,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_EXPECT_SYNC
  } daq_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/daq_sample_skid.sv
// One-byte hold register plus sample output register with valid/ready handshake.
// Decides which byte (held or fresh from the FIFO) the FSM processes each cycle.
module daq_sample_skid
  import daq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  input  logic              lo_state,
  input  logic [7:0]        msb,
  input  logic [CHIP_W-1:0] chip,
  input  logic [CHAN_W-1:0] chan,
  input  logic              last,
  input  logic              ready,
  output logic              proc_valid,
  output logic [7:0]        proc_byte,
  output logic              hold_v,
  output logic              stalled,
  output logic              last_accept,
  output logic [15:0]       sample,
  output logic [CHIP_W-1:0] sample_chip,
  output logic [CHAN_W-1:0] sample_chan,
  output logic              sample_valid,
  output logic              frame_start,
  output logic              frame_done
);

  logic [7:0] hold_byte;
  logic       start_q;
  logic       last_q;
  logic       accept;
  logic       capture;
  logic       load;

  // A low byte that cannot reach a blocked output is parked; everything else flows to the FSM.
  assign stalled     = sample_valid & ~ready;
  assign accept      = sample_valid & ready;
  assign capture     = byte_valid & lo_state & stalled;
  assign proc_valid  = (hold_v & ~stalled) | (byte_valid & ~capture);
  assign proc_byte   = hold_v ? hold_byte : byte_data;
  assign load        = proc_valid & lo_state;
  assign last_accept = accept & last_q;
  assign frame_start = start_q & sample_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v       <= 1'b0;
      hold_byte    <= 8'h00;
      sample       <= 16'h0000;
      sample_chip  <= '0;
      sample_chan  <= '0;
      sample_valid <= 1'b0;
      start_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (capture) begin
        hold_v    <= 1'b1;
        hold_byte <= byte_data;
      end else if (hold_v && !stalled) begin
        hold_v <= 1'b0;
      end
      frame_done <= last_accept;
      if (load) begin
        sample       <= {msb, proc_byte};
        sample_chip  <= chip;
        sample_chan  <= chan;
        start_q      <= (chip == '0) && (chan == '0);
        last_q       <= last;
        sample_valid <= 1'b1;
      end else if (accept) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/daq_depacketizer.sv
// Consumes the packetizer byte FIFO, locks onto frame sync, checks sequence numbers
// and emits 16-bit samples tagged with chip and channel index.
module daq_depacketizer
  import daq_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              fifo_empty_i,
  output logic              fifo_req_o,
  input  logic [7:0]        fifo_data_i,
  output logic [15:0]       sample_o,
  output logic [CHIP_W-1:0] chip_o,
  output logic [CHAN_W-1:0] chan_o,
  output logic              sample_valid_o,
  input  logic              sample_ready_i,
  output logic              frame_start_o,
  output logic              frame_done_o,
  output logic [7:0]        seq_o,
  output logic              locked_o,
  output logic [15:0]       sync_err_cnt_o,
  output logic [15:0]       seq_err_cnt_o
);

  daq_state_e        state;
  daq_state_e        next_state;
  logic              rd_pend;
  logic              proc_valid;
  logic [7:0]        proc_byte;
  logic              hold_v;
  logic              stalled;
  logic              last_accept;
  logic [7:0]        msb_q;
  logic [CHIP_W-1:0] chip_cnt;
  logic [CHAN_W-1:0] chan_cnt;
  logic              last_sample;
  logic              prev_valid;
  logic              sync_err_inc;
  logic              drop_lock;
  logic              seq_gap;

  assign fifo_req_o  = reset_i & ~fifo_empty_i & ~hold_v & ~stalled;
  assign last_sample = (chip_cnt == CHIP_W'(NUM_CHIPS - 1)) && (chan_cnt == CHAN_W'(NUM_CHAN - 1));

  daq_sample_skid u_skid (
    .clk          (clk_i),
    .rst_n        (reset_i),
    .byte_valid   (rd_pend),
    .byte_data    (fifo_data_i),
    .lo_state     (state == ST_DATA_LO),
    .msb          (msb_q),
    .chip         (chip_cnt),
    .chan         (chan_cnt),
    .last         (last_sample),
    .ready        (sample_ready_i),
    .proc_valid   (proc_valid),
    .proc_byte    (proc_byte),
    .hold_v       (hold_v),
    .stalled      (stalled),
    .last_accept  (last_accept),
    .sample       (sample_o),
    .sample_chip  (chip_o),
    .sample_chan  (chan_o),
    .sample_valid (sample_valid_o),
    .frame_start  (frame_start_o),
    .frame_done   (frame_done_o)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= ST_HUNT;
    else          state <= next_state;
  end

  // One transition per processed byte; a repeated SYNC0 while waiting for SYNC1 keeps the lock attempt.
  always_comb begin
    next_state   = state;
    sync_err_inc = 1'b0;
    drop_lock    = 1'b0;
    seq_gap      = 1'b0;
    if (proc_valid) begin
      unique case (state)
        ST_HUNT: begin
          if (proc_byte == SYNC0) next_state = ST_SYNC1;
        end
        ST_SYNC1: begin
          if (proc_byte == SYNC1) begin
            next_state = ST_SEQ;
          end else if (proc_byte != SYNC0) begin
            next_state   = ST_HUNT;
            sync_err_inc = locked_o;
            drop_lock    = 1'b1;
          end
        end
        ST_SEQ: begin
          seq_gap    = prev_valid && (proc_byte != 8'(seq_o + 8'd1));
          next_state = ST_DATA_HI;
        end
        ST_DATA_HI: next_state = ST_DATA_LO;
        ST_DATA_LO: next_state = last_sample ? ST_EXPECT_SYNC : ST_DATA_HI;
        ST_EXPECT_SYNC: begin
          if (proc_byte == SYNC0) begin
            next_state = ST_SYNC1;
          end else begin
            next_state   = ST_HUNT;
            sync_err_inc = 1'b1;
            drop_lock    = 1'b1;
          end
        end
        default: next_state = ST_HUNT;
      endcase
    end
  end

  // Loss of lock wins over a simultaneous frame completion.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rd_pend        <= 1'b0;
      msb_q          <= 8'h00;
      chip_cnt       <= '0;
      chan_cnt       <= '0;
      seq_o          <= 8'h00;
      prev_valid     <= 1'b0;
      locked_o       <= 1'b0;
      sync_err_cnt_o <= 16'h0000;
      seq_err_cnt_o  <= 16'h0000;
    end else begin
      rd_pend <= fifo_req_o;
      if (sync_err_inc) sync_err_cnt_o <= sat_inc(sync_err_cnt_o);
      if (seq_gap)      seq_err_cnt_o  <= sat_inc(seq_err_cnt_o);
      if (drop_lock) begin
        locked_o   <= 1'b0;
        prev_valid <= 1'b0;
      end else if (last_accept) begin
        locked_o <= 1'b1;
      end
      if (proc_valid) begin
        case (state)
          ST_SEQ: begin
            seq_o    <= proc_byte;
            chip_cnt <= '0;
            chan_cnt <= '0;
          end
          ST_DATA_HI: msb_q <= proc_byte;
          ST_DATA_LO: begin
            if (chan_cnt == CHAN_W'(NUM_CHAN - 1)) begin
              chan_cnt <= '0;
              chip_cnt <= chip_cnt + 1'b1;
            end else begin
              chan_cnt <= chan_cnt + 1'b1;
            end
            if (last_sample) prev_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_depacketizer.sv
// Directed bench for daq_depacketizer: FIFO byte model, sample scoreboard and
// phase-level checks of lock, sequence and error-counter behaviour.
module tb_daq_depacketizer;
  import daq_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        fifo_empty_i;
  logic        fifo_req_o;
  logic [7:0]  fifo_data_i;
  logic [15:0] sample_o;
  logic [2:0]  chip_o;
  logic [2:0]  chan_o;
  logic        sample_valid_o;
  logic        sample_ready_i;
  logic        frame_start_o;
  logic        frame_done_o;
  logic [7:0]  seq_o;
  logic        locked_o;
  logic [15:0] sync_err_cnt_o;
  logic [15:0] seq_err_cnt_o;

  logic [7:0]  fifo_q[$];
  logic [22:0] exp_q[$];
  logic [22:0] exp_item;
  logic [15:0] held;
  bit          sb_on;
  int test_cnt = 0, fail_cnt = 0;
  int samples_seen = 0, starts_seen = 0, dones_seen = 0, lock_low_cnt = 0;
  int s0, st0, d0, lk0;

  daq_depacketizer dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_req_o     (fifo_req_o),
    .fifo_data_i    (fifo_data_i),
    .sample_o       (sample_o),
    .chip_o         (chip_o),
    .chan_o         (chan_o),
    .sample_valid_o (sample_valid_o),
    .sample_ready_i (sample_ready_i),
    .frame_start_o  (frame_start_o),
    .frame_done_o   (frame_done_o),
    .seq_o          (seq_o),
    .locked_o       (locked_o),
    .sync_err_cnt_o (sync_err_cnt_o),
    .seq_err_cnt_o  (seq_err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // FIFO model: data appears the cycle after a request
  always @(posedge clk_i) begin
    if (fifo_req_o && fifo_q.size() != 0) fifo_data_i <= fifo_q.pop_front();
  end

  always @(negedge clk_i) fifo_empty_i = (fifo_q.size() == 0);

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard: every accepted sample must match the next expected {start, chip, chan, sample}
  always @(negedge clk_i) begin
    if (sb_on && sample_valid_o && sample_ready_i) begin
      samples_seen++;
      if (frame_start_o) starts_seen++;
      if (exp_q.size() == 0) begin
        checkOutput("extra_sample", {9'd0, frame_start_o, chip_o, chan_o, sample_o}, 32'hFFFF_FFFF);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("sample", {9'd0, frame_start_o, chip_o, chan_o, sample_o}, {9'd0, exp_item});
      end
    end
    if (frame_done_o) dones_seen++;
    if (!locked_o) lock_low_cnt++;
  end

  // Frame: first_byte, SYNC1, seq, then 64 samples {00,chip,chan,seq+index}
  task automatic applyStimulus(input logic [7:0] seq, input bit decode, input logic [7:0] first_byte);
    logic [15:0] val;
    fifo_q.push_back(first_byte);
    fifo_q.push_back(8'h55);
    fifo_q.push_back(seq);
    for (int i = 0; i < 64; i++) begin
      val = {2'b00, 3'(i / 8), 3'(i % 8), 8'(int'(seq) + i)};
      fifo_q.push_back(val[15:8]);
      fifo_q.push_back(val[7:0]);
      if (decode) exp_q.push_back({(i == 0), 3'(i / 8), 3'(i % 8), val});
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 5000) begin
      @(posedge clk_i);
      n++;
    end
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput(tag, 32'(n >= 5000), 32'd0);
  endtask

  task automatic waitConsumed(input int remain, input string tag);
    int n = 0;
    while (fifo_q.size() > remain && n < 2000) begin
      @(posedge clk_i);
      n++;
    end
    checkOutput(tag, 32'(n >= 2000), 32'd0);
  endtask

  task automatic markCounts();
    s0 = samples_seen; st0 = starts_seen; d0 = dones_seen; lk0 = lock_low_cnt;
  endtask

  initial begin
    reset_i = 1'b0; fifo_empty_i = 1'b1; fifo_data_i = 8'h00; sample_ready_i = 1'b1; sb_on = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_req", 32'(fifo_req_o), 32'd0);
    @(posedge clk_i); #1 reset_i = 1'b1;
    checkOutput("rst_valid", 32'(sample_valid_o), 32'd0);
    checkOutput("rst_locked", 32'(locked_o), 32'd0);
    checkOutput("rst_sample", 32'(sample_o), 32'd0);
    checkOutput("rst_errs", {sync_err_cnt_o, seq_err_cnt_o}, 32'd0);

    // Garbage ahead of two good frames
    markCounts();
    fifo_q.push_back(8'h12); fifo_q.push_back(8'hAA); fifo_q.push_back(8'h00);
    applyStimulus(8'h00, 1'b1, SYNC0);
    applyStimulus(8'h01, 1'b1, SYNC0);
    drain("a_timeout");
    checkOutput("a_samples", 32'(samples_seen - s0), 32'd128);
    checkOutput("a_starts", 32'(starts_seen - st0), 32'd2);
    checkOutput("a_dones", 32'(dones_seen - d0), 32'd2);
    checkOutput("a_locked", 32'(locked_o), 32'd1);
    checkOutput("a_sync_err", 32'(sync_err_cnt_o), 32'd0);
    checkOutput("a_seq_err", 32'(seq_err_cnt_o), 32'd0);
    checkOutput("a_seq", 32'(seq_o), 32'h01);

    // Reset after byte 40 of a frame, then a run with a sequence gap
    sb_on = 1'b0;
    applyStimulus(8'h02, 1'b0, SYNC0);
    waitConsumed(131 - 41, "b_wait_timeout");
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b_rst_req", 32'(fifo_req_o), 32'd0);
    @(posedge clk_i); #1 reset_i = 1'b1;
    checkOutput("b_rst_valid", 32'(sample_valid_o), 32'd0);
    checkOutput("b_rst_flags", {29'd0, frame_start_o, frame_done_o, locked_o}, 32'd0);
    checkOutput("b_rst_seq", 32'(seq_o), 32'd0);
    checkOutput("b_rst_sample", {10'd0, chip_o, chan_o, sample_o}, 32'd0);
    sb_on = 1'b1;
    markCounts();
    applyStimulus(8'hFE, 1'b1, SYNC0);
    applyStimulus(8'hFF, 1'b1, SYNC0);
    applyStimulus(8'h00, 1'b1, SYNC0);
    applyStimulus(8'h02, 1'b1, SYNC0);
    drain("b_timeout");
    checkOutput("b_samples", 32'(samples_seen - s0), 32'd256);
    checkOutput("b_dones", 32'(dones_seen - d0), 32'd4);
    checkOutput("b_seq_err", 32'(seq_err_cnt_o), 32'd1);
    checkOutput("b_sync_err", 32'(sync_err_cnt_o), 32'd0);
    checkOutput("b_locked", 32'(locked_o), 32'd1);
    checkOutput("b_seq", 32'(seq_o), 32'h02);

    // Third frame's SYNC0 corrupted: lock lost, resync, gap after resync not counted
    markCounts();
    applyStimulus(8'h03, 1'b1, SYNC0);
    applyStimulus(8'h04, 1'b0, 8'h00);
    applyStimulus(8'h09, 1'b1, SYNC0);
    drain("c_timeout");
    checkOutput("c_sync_err", 32'(sync_err_cnt_o), 32'd1);
    checkOutput("c_seq_err", 32'(seq_err_cnt_o), 32'd1);
    checkOutput("c_lock_dropped", 32'(lock_low_cnt != lk0), 32'd1);
    checkOutput("c_locked", 32'(locked_o), 32'd1);
    checkOutput("c_samples", 32'(samples_seen - s0), 32'd128);
    checkOutput("c_dones", 32'(dones_seen - d0), 32'd2);
    checkOutput("c_seq", 32'(seq_o), 32'h09);

    // Downstream stall mid-frame with a full FIFO
    markCounts();
    applyStimulus(8'h0A, 1'b1, SYNC0);
    waitConsumed(131 - 60, "d_wait_timeout");
    #1 sample_ready_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("d_stall_valid", 32'(sample_valid_o), 32'd1);
    checkOutput("d_stall_req", 32'(fifo_req_o), 32'd0);
    held = sample_o;
    repeat (3) begin
      @(negedge clk_i);
      checkOutput("d_stall_hold", 32'(sample_o), 32'(held));
      checkOutput("d_stall_req_low", 32'(fifo_req_o), 32'd0);
    end
    @(posedge clk_i); #1 sample_ready_i = 1'b1;
    drain("d_timeout");
    checkOutput("d_samples", 32'(samples_seen - s0), 32'd64);
    checkOutput("d_dones", 32'(dones_seen - d0), 32'd1);
    checkOutput("d_locked", 32'(locked_o), 32'd1);
    checkOutput("d_seq_err", 32'(seq_err_cnt_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
